// File: rtl/t08_lcd_scheduler_if.sv
// t08_lcd_scheduler <-> t08_spi command engine link.
// Scheduler is master, engine is slave.
interface t08_lcd_scheduler_if;
  logic        spi_busy;
  logic        spi_enable;
  logic [7:0]  spi_command;
  logic [31:0] spi_parameters;
  logic [3:0]  spi_counter;
  logic        spi_readwrite;

  modport master (
    input  spi_busy,
    output spi_enable,
    output spi_command,
    output spi_parameters,
    output spi_counter,
    output spi_readwrite
  );

  modport slave (
    output spi_busy,
    input  spi_enable,
    input  spi_command,
    input  spi_parameters,
    input  spi_counter,
    input  spi_readwrite
  );
endinterface

// File: rtl/t08_lcd_scheduler.sv
// LCD init sequencer and round-robin arbiter
// sharing one t08_spi command/parameter engine.
module t08_lcd_scheduler #(
  parameter logic [15:0] RST_DELAY = 16'd5000,
  parameter logic [15:0] SLP_DELAY = 16'd6000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [1:0]  req,
  input  logic [7:0]  req_cmd0,
  input  logic [7:0]  req_cmd1,
  input  logic [31:0] req_par0,
  input  logic [31:0] req_par1,
  input  logic [3:0]  req_cnt0,
  input  logic [3:0]  req_cnt1,
  input  logic        req_rw0,
  input  logic        req_rw1,
  output logic [1:0]  grant,
  output logic [1:0]  done,
  output logic        init_done,
  t08_lcd_scheduler_if.master spi
);

  typedef enum logic [2:0] {
    INIT_ISSUE,
    INIT_WAIT_BUSY,
    INIT_WAIT_DONE,
    INIT_DELAY,
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] dly_q, dly_d;
  logic        init_done_q, init_done_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  done_q, done_d;
  logic        rr_last_q, rr_last_d;
  logic        port_q, port_d;
  logic        en_q, en_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [31:0] par_q, par_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;

  logic [7:0]  ini_cmd;
  logic [3:0]  ini_cnt;
  logic [31:0] ini_par;
  logic        sel;

  function automatic logic [3:0] clamp(
    input logic [3:0] c
  );
    return (c > 4'd4) ? 4'd4 : c;
  endfunction

  // Fixed LCD bring-up table; all entries are writes.
  always_comb begin
    ini_cmd = 8'h00;
    ini_cnt = 4'd0;
    ini_par = 32'h0;
    unique case (idx_q)
      2'd0: ini_cmd = 8'h01;
      2'd1: ini_cmd = 8'h11;
      2'd2: begin
        ini_cmd = 8'h3A;
        ini_cnt = 4'd1;
        ini_par = 32'h5500_0000;
      end
      2'd3: ini_cmd = 8'h29;
      default: ini_cmd = 8'h00;
    endcase
  end

  // Contended requests go to the port not served last.
  always_comb begin
    sel = (&req) ? ~rr_last_q : ~req[0];
  end

  // Next-state, handshake and arbitration logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dly_d       = dly_q;
    init_done_d = init_done_q;
    grant_d     = grant_q;
    done_d      = 2'b00;
    rr_last_d   = rr_last_q;
    port_d      = port_q;
    en_d        = en_q;
    cmd_d       = cmd_q;
    par_d       = par_q;
    cnt_d       = cnt_q;
    rw_d        = rw_q;
    unique case (state_q)
      INIT_ISSUE: begin
        en_d    = 1'b1;
        cmd_d   = ini_cmd;
        cnt_d   = ini_cnt;
        par_d   = ini_par;
        rw_d    = 1'b1;
        state_d = INIT_WAIT_BUSY;
      end
      INIT_WAIT_BUSY: begin
        if (spi.spi_busy) begin
          en_d    = 1'b0;
          state_d = INIT_WAIT_DONE;
        end
      end
      INIT_WAIT_DONE: begin
        if (!spi.spi_busy) begin
          unique case (idx_q)
            2'd0: begin
              dly_d   = RST_DELAY;
              state_d = INIT_DELAY;
            end
            2'd1: begin
              dly_d   = SLP_DELAY;
              state_d = INIT_DELAY;
            end
            2'd2: begin
              idx_d   = idx_q + 2'd1;
              state_d = INIT_ISSUE;
            end
            default: begin
              init_done_d = 1'b1;
              state_d     = IDLE;
            end
          endcase
        end
      end
      INIT_DELAY: begin
        if (dly_q == 16'd0) begin
          idx_d   = idx_q + 2'd1;
          state_d = INIT_ISSUE;
        end else begin
          dly_d = dly_q - 16'd1;
        end
      end
      IDLE: begin
        if (req != 2'b00) begin
          port_d  = sel;
          grant_d = sel ? 2'b10 : 2'b01;
          en_d    = 1'b1;
          cmd_d   = sel ? req_cmd1 : req_cmd0;
          par_d   = sel ? req_par1 : req_par0;
          cnt_d   = clamp(sel ? req_cnt1 : req_cnt0);
          rw_d    = sel ? req_rw1 : req_rw0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (spi.spi_busy) begin
          en_d    = 1'b0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!spi.spi_busy) begin
          done_d    = port_q ? 2'b10 : 2'b01;
          grant_d   = 2'b00;
          rr_last_d = port_q;
          state_d   = IDLE;
        end
      end
      default: state_d = INIT_ISSUE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= INIT_ISSUE;
      idx_q       <= 2'd0;
      dly_q       <= 16'd0;
      init_done_q <= 1'b0;
      grant_q     <= 2'b00;
      done_q      <= 2'b00;
      rr_last_q   <= 1'b1;
      port_q      <= 1'b0;
      en_q        <= 1'b0;
      cmd_q       <= 8'h00;
      par_q       <= 32'h0;
      cnt_q       <= 4'd0;
      rw_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dly_q       <= dly_d;
      init_done_q <= init_done_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      rr_last_q   <= rr_last_d;
      port_q      <= port_d;
      en_q        <= en_d;
      cmd_q       <= cmd_d;
      par_q       <= par_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
    end
  end

  assign grant              = grant_q;
  assign done               = done_q;
  assign init_done          = init_done_q;
  assign spi.spi_enable     = en_q;
  assign spi.spi_command    = cmd_q;
  assign spi.spi_parameters = par_q;
  assign spi.spi_counter    = cnt_q;
  assign spi.spi_readwrite  = rw_q;

endmodule

// File: doc/t08_lcd_scheduler.md
Name: t08_lcd_scheduler

Overview:
- Sequences and shares the t08_spi LCD command/parameter engine.
- After reset it runs a fixed LCD init sequence: software reset, sleep out, pixel format, display on, with delays after reset and after sleep out.
- It then arbitrates round-robin between two requesters: port 0 (CPU MMIO) and port 1 (frame/pixel writer).
- Exactly one transaction is handed to t08_spi at a time, and every transaction is held until t08_spi reports completion through busy.

Parameters:
- RST_DELAY, 16'd5000: idle cycles after the 0x01 software reset command completes.
- SLP_DELAY, 16'd6000: idle cycles after the 0x11 sleep-out command completes.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- req  in  2  per-requester transaction request, held until its done pulse
- req_cmd0 / req_cmd1  in  8 each  command byte
- req_par0 / req_par1  in  32 each  parameter bytes, MSB byte sent first
- req_cnt0 / req_cnt1  in  4 each  parameter byte count, 0..4
- req_rw0 / req_rw1  in  1 each  1 = write, 0 = read
- grant  out  2  one-hot, high while that requester owns the engine
- done  out  2  one-cycle pulse when that requester's transaction completes
- init_done  out  1  high once the init sequence has finished
- spi_busy  in  1  busy from t08_spi
- spi_enable  out  1  start request to t08_spi
- spi_command  out  8  command to t08_spi
- spi_parameters  out  32  parameters to t08_spi
- spi_counter  out  4  parameter count to t08_spi
- spi_readwrite  out  1  read/write select to t08_spi

Behaviour:
- Reset (nrst low, asynchronous):
  - state = INIT_ISSUE, init index = 0, delay counter = 0.
  - All outputs 0, except spi_readwrite = 1.
  - rr_last = 1, so port 0 has priority first.
- Init table, indexed 0..3, entries as {cmd, cnt, params}:
  - 0: 0x01, 0, 0
  - 1: 0x11, 0, 0
  - 2: 0x3A, 1, 0x55000000
  - 3: 0x29, 0, 0
  - All entries are writes.
- Handshake with t08_spi, applied to every transaction:
  - ISSUE: drive cmd/params/cnt/rw and spi_enable = 1.
  - WAIT_BUSY: keep outputs stable and spi_enable high until spi_busy = 1 is sampled, then drop spi_enable on the next edge.
  - WAIT_DONE: wait for spi_busy = 0. The transaction is complete on the cycle spi_busy is first sampled low.
  - spi_command, spi_parameters and spi_counter hold their last values in idle. spi_enable is the only qualifier.
- FSM states: INIT_ISSUE, INIT_WAIT_BUSY, INIT_WAIT_DONE, INIT_DELAY, IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- Init flow:
  - INIT_ISSUE → INIT_WAIT_BUSY → INIT_WAIT_DONE.
  - On completion of index 0 or 1, go to INIT_DELAY and load RST_DELAY or SLP_DELAY respectively. INIT_DELAY counts down to 0, then increments the index and returns to INIT_ISSUE.
  - On completion of index 2, increment the index and go to INIT_ISSUE.
  - On completion of index 3, set init_done = 1 (sticky until reset) and go to IDLE.
- req is ignored during init. No grant is issued and no done pulse is produced before init_done.
- Arbitration, in IDLE:
  - If both req bits are set, grant the port other than rr_last.
  - Otherwise grant the single requester.
  - The grant is registered and goes high one cycle after IDLE samples req. The FSM enters ISSUE in that same cycle and latches the granted port's fields.
- On WAIT_DONE completion:
  - Pulse done[p] for 1 cycle, clear grant the same cycle, set rr_last = p, return to IDLE.
  - Minimum gap between back-to-back transactions is 1 IDLE cycle.
- A requester that drops req while granted does not abort the transaction. It still receives done.
- req_cnt values greater than 4 are clamped to 4.
- Reset mid-operation returns immediately to reset values and reruns the full init sequence.
- A spi_busy glitch while in IDLE is ignored.

Test Plan:
- Release reset, with t08_spi modelled as busy for 10 cycles after enable:
  - spi_command sequence is 0x01, 0x11, 0x3A, 0x29.
  - The 0x3A entry shows cnt = 1 and params = 0x55000000.
  - Idle gaps after 0x01 and 0x11 are ≥ RST_DELAY and ≥ SLP_DELAY cycles respectively (use 8/12 in sim).
  - init_done rises after 0x29 completes.
- Assert req = 2'b01 during init: no grant until init_done. Then grant = 01, spi_command = req_cmd0 = 0x2C, done[0] pulses once.
- Hold req = 2'b11 continuously with port 0 cmd 0x2A and port 1 cmd 0x2B: grants alternate 01, 10, 01, 10 and commands alternate 0x2A, 0x2B.
- Port 1 issues a read with rw = 0, cnt = 4, par = 0x0FAA33F0: spi_readwrite = 0, spi_parameters = 0x0FAA33F0, spi_counter = 4.
- Delay spi_busy 5 cycles after enable: spi_enable stays high with stable outputs until busy rises, then goes low.
- Pulse nrst low during a granted transaction: all outputs return to reset values asynchronously, and the init sequence restarts at 0x01.
